// File: rtl/dsi_rx_packet_decoder.sv
// rtl/dsi_rx_packet_decoder.sv - DSI link-layer packet decoder (header ECC, payload stream, CRC-16)
//
// Splits a merged D-PHY HS byte stream into DSI packets. Every header has its
// ECC checked, and single-bit errors are corrected. Long-packet payload is
// streamed out with one cycle of latency, and the trailing CRC-16 is checked.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/valid/sot/eot       HS byte stream from the lane receiver
//   hdr_valid/vc/dt/wc/long     decoded header (pulse + held fields)
//   ecc_corr, ecc_err           header ECC status, qualified by hdr_valid
//   pl_data/valid/last          payload byte stream
//   pkt_done, crc_err           long packet finished and CRC status
//   len_err, trunc_err          word count too large / burst cut mid-packet
module dsi_rx_packet_decoder #(
  parameter logic [15:0] MAX_WC    = 16'd4096,
  parameter bit          CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sot,
  input  logic        in_eot,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        ecc_corr,
  output logic        ecc_err,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  output logic        pkt_done,
  output logic        crc_err,
  output logic        len_err,
  output logic        trunc_err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_SKIP} state_t;

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic [7:0]  hb0, hb1, hb2;
  logic [15:0] cnt;
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic        crc_idx;

  // DSI header ECC: six parity bits over the 24 header data bits.
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CCITT CRC-16 (0x8408), one byte, LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  // Header decode, evaluated while the ECC byte (4th header byte) is on in_data.
  logic [23:0] hd_raw, hd_fix;
  logic [5:0]  hd_syn;
  logic        hd_hit, hd_corr, hd_err, hd_long;
  logic [15:0] hd_wc;

  always_comb begin
    hd_raw = {hb2, hb1, hb0};
    hd_syn = ecc_calc(hd_raw) ^ in_data[5:0];
    hd_fix = hd_raw;
    hd_hit = 1'b0;
    // A syndrome equal to a data bit's ECC column identifies that bit.
    for (int i = 0; i < 24; i++) begin
      if (hd_syn == ecc_calc(24'd1 << i)) begin
        hd_fix[i] = ~hd_raw[i];
        hd_hit    = 1'b1;
      end
    end
    // A single-bit syndrome means only a parity bit was hit.
    hd_corr = hd_hit || $onehot(hd_syn);
    hd_err  = (hd_syn != 6'd0) && !hd_corr;
    hd_wc   = hd_fix[23:8];
    case (hd_fix[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: hd_long = 1'b1;
      default:                hd_long = 1'b0;
    endcase
  end

  // pkt_open: a packet is partly received right now.
  // open_after: a packet is still partly received after this cycle's byte,
  // which is what an eot arriving in the same cycle has to judge.
  logic pkt_open, open_after;

  always_comb begin
    pkt_open = (state == S_HDR && hdr_cnt != 2'd0) || state == S_PAYLOAD || state == S_CRC;
    open_after = pkt_open;
    if (in_valid) begin
      if (in_sot && state != S_SKIP) begin
        open_after = 1'b1;
      end else begin
        case (state)
          S_HDR:     open_after = (hdr_cnt != 2'd3) || (hd_long && !hd_err && hd_wc <= MAX_WC);
          S_PAYLOAD: open_after = 1'b1;
          S_CRC:     open_after = !crc_idx;
          default:   open_after = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hdr_cnt   <= 2'd0;
      hb0       <= 8'd0;
      hb1       <= 8'd0;
      hb2       <= 8'd0;
      cnt       <= 16'd0;
      crc       <= 16'd0;
      crc_lo    <= 8'd0;
      crc_idx   <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_vc    <= 2'd0;
      hdr_dt    <= 6'd0;
      hdr_wc    <= 16'd0;
      hdr_long  <= 1'b0;
      ecc_corr  <= 1'b0;
      ecc_err   <= 1'b0;
      pl_data   <= 8'd0;
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      pkt_done  <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      ecc_corr  <= 1'b0;
      ecc_err   <= 1'b0;
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      pkt_done  <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      trunc_err <= 1'b0;

      if (in_valid) begin
        if (in_sot && state != S_SKIP) begin
          // New burst: any partial packet is abandoned, this byte is DI.
          if (pkt_open) trunc_err <= 1'b1;
          hb0     <= in_data;
          hdr_cnt <= 2'd1;
          crc_idx <= 1'b0;
          state   <= S_HDR;
        end else begin
          case (state)
            S_HDR: begin
              hdr_cnt <= hdr_cnt + 2'd1;
              case (hdr_cnt)
                2'd0: hb0 <= in_data;
                2'd1: hb1 <= in_data;
                2'd2: hb2 <= in_data;
                default: begin
                  hdr_valid <= 1'b1;
                  hdr_vc    <= hd_fix[7:6];
                  hdr_dt    <= hd_fix[5:0];
                  hdr_wc    <= hd_wc;
                  hdr_long  <= hd_long;
                  ecc_corr  <= hd_corr;
                  ecc_err   <= hd_err;
                  crc       <= 16'hFFFF;
                  crc_idx   <= 1'b0;
                  if (hd_err) begin
                    state <= S_SKIP;
                  end else if (hd_long) begin
                    if (hd_wc > MAX_WC) begin
                      len_err <= 1'b1;
                      state   <= S_SKIP;
                    end else if (hd_wc == 16'd0) begin
                      state <= S_CRC;
                    end else begin
                      cnt   <= hd_wc;
                      state <= S_PAYLOAD;
                    end
                  end
                end
              endcase
            end
            S_PAYLOAD: begin
              pl_data  <= in_data;
              pl_valid <= 1'b1;
              crc      <= crc_byte(crc, in_data);
              cnt      <= cnt - 16'd1;
              if (cnt == 16'd1) begin
                pl_last <= 1'b1;
                state   <= S_CRC;
              end
            end
            S_CRC: begin
              if (!crc_idx) begin
                crc_lo  <= in_data;
                crc_idx <= 1'b1;
              end else begin
                pkt_done <= 1'b1;
                crc_err  <= CHECK_CRC && ({in_data, crc_lo} != crc);
                crc_idx  <= 1'b0;
                state    <= S_HDR;
              end
            end
            default: ;
          endcase
        end
      end

      // Eot is applied after any byte in the same cycle.
      if (in_eot) begin
        state   <= S_IDLE;
        hdr_cnt <= 2'd0;
        crc_idx <= 1'b0;
        if (open_after) trunc_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsi_rx_packet_decoder.sv
// tb/tb_dsi_rx_packet_decoder.sv - table-driven bench for dsi_rx_packet_decoder
module tb_dsi_rx_packet_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_sot, in_eot;

  logic        hdr_valid, hdr_long, ecc_corr, ecc_err, pl_valid, pl_last;
  logic        pkt_done, crc_err, len_err, trunc_err;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [7:0]  pl_data;

  logic        c0_hdr_valid, c0_hdr_long, c0_ecc_corr, c0_ecc_err, c0_pl_valid, c0_pl_last;
  logic        c0_pkt_done, c0_crc_err, c0_len_err, c0_trunc_err;
  logic [1:0]  c0_hdr_vc;
  logic [5:0]  c0_hdr_dt;
  logic [15:0] c0_hdr_wc;
  logic [7:0]  c0_pl_data;

  dsi_rx_packet_decoder #(.MAX_WC(16'd4096), .CHECK_CRC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sot(in_sot),
    .in_eot(in_eot), .hdr_valid(hdr_valid), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt), .hdr_wc(hdr_wc),
    .hdr_long(hdr_long), .ecc_corr(ecc_corr), .ecc_err(ecc_err), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_last(pl_last), .pkt_done(pkt_done), .crc_err(crc_err),
    .len_err(len_err), .trunc_err(trunc_err)
  );

  dsi_rx_packet_decoder #(.MAX_WC(16'd4096), .CHECK_CRC(1'b0)) dut_nocrc (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sot(in_sot),
    .in_eot(in_eot), .hdr_valid(c0_hdr_valid), .hdr_vc(c0_hdr_vc), .hdr_dt(c0_hdr_dt),
    .hdr_wc(c0_hdr_wc), .hdr_long(c0_hdr_long), .ecc_corr(c0_ecc_corr), .ecc_err(c0_ecc_err),
    .pl_data(c0_pl_data), .pl_valid(c0_pl_valid), .pl_last(c0_pl_last),
    .pkt_done(c0_pkt_done), .crc_err(c0_crc_err), .len_err(c0_len_err),
    .trunc_err(c0_trunc_err)
  );

  int tests = 0;
  int fails = 0;

  // Output monitor: cumulative event counts, sampled away from the active edge.
  int         n_hdr = 0, n_last = 0, n_done = 0, n_done2 = 0, n_len = 0, n_trunc = 0, n_overlap = 0;
  logic [1:0]  m_vc = 0;
  logic [5:0]  m_dt = 0;
  logic [15:0] m_wc = 0;
  logic        m_long = 0, m_corr = 0, m_err = 0, m_crc = 0, m_crc2 = 0;
  logic [7:0]  pl_log[$];

  always @(negedge clk) begin
    if (hdr_valid) begin
      n_hdr  <= n_hdr + 1;
      m_vc   <= hdr_vc;
      m_dt   <= hdr_dt;
      m_wc   <= hdr_wc;
      m_long <= hdr_long;
      m_corr <= ecc_corr;
      m_err  <= ecc_err;
    end
    if (pl_valid) pl_log.push_back(pl_data);
    if (pl_valid && pl_last) n_last <= n_last + 1;
    if (pkt_done) begin
      n_done <= n_done + 1;
      m_crc  <= crc_err;
    end
    if (c0_pkt_done) begin
      n_done2 <= n_done2 + 1;
      m_crc2  <= c0_crc_err;
    end
    if (len_err) n_len <= n_len + 1;
    if (trunc_err) n_trunc <= n_trunc + 1;
    if (hdr_valid && pl_valid) n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [23:0] bytes, input int n);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      d = bytes[23 - 8*k -: 8];
      c = c ^ {8'h00, d};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // eot_mode: 0 = eot on the cycle after the last byte, 1 = with the last byte, 2 = no eot
  task automatic send(input logic [0:11][7:0] b, input int n, input bit with_sot, input int eot_mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[i];
      in_sot   = with_sot && (i == 0);
      in_eot   = (eot_mode == 1) && (i == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sot   = 1'b0;
    in_eot   = (eot_mode == 0);
    @(negedge clk);
    in_eot = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string            name;
    int               n;
    logic [0:11][7:0] b;
    int eot_mode, e_hdr, e_dt, e_wc, e_long, e_corr, e_err;
    int e_pl, e_last, e_done, e_crc, e_crc2, e_len, e_trunc;
  } vec_t;

  localparam int NV = 12;
  vec_t v[NV];

  int s_hdr, s_pl, s_last, s_done, s_done2, s_len, s_trunc;
  logic [15:0] good_crc;

  task automatic snap();
    s_hdr = n_hdr; s_pl = pl_log.size(); s_last = n_last; s_done = n_done;
    s_done2 = n_done2; s_len = n_len; s_trunc = n_trunc;
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_long, ecc_corr, ecc_err, pl_data,
             pl_valid, pl_last, pkt_done, crc_err, len_err, trunc_err}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_sot = 1'b0; in_eot = 1'b0;

    good_crc = crc_model(24'h2CAABB, 3);
    //          name            n   bytes                                                        eot hdr dt     wc       lg co er pl la dn crc c2 len tr
    v[0]  = '{"short_clean",    4, {8'h05,8'h11,8'h00,8'h36,64'h0},                                0, 1, 'h05, 'h0011,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{"d9_flip",        4, {8'h05,8'h13,8'h00,8'h36,64'h0},                                0, 1, 'h05, 'h0011,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{"two_flip",       4, {8'h05,8'h12,8'h00,8'h36,64'h0},                                0, 1, 'h05, 'h0000,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{"after_err",      4, {8'h05,8'h11,8'h00,8'h36,64'h0},                                0, 1, 'h05, 'h0011,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4]  = '{"parity_flip",    4, {8'h05,8'h11,8'h00,8'h37,64'h0},                                0, 1, 'h05, 'h0011,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[5]  = '{"long_ok",        9, {8'h39,8'h03,8'h00,8'h09,8'h2C,8'hAA,8'hBB,8'h00,8'h00,24'h0},   0, 1, 'h39, 'h0003,  1, 0, 0, 3, 1, 1, 0, 0, 0, 0};
    v[5].b[7] = good_crc[7:0];
    v[5].b[8] = good_crc[15:8];
    v[6] = v[5];
    v[6].name  = "long_badcrc";
    v[6].b[7]  = v[5].b[7] ^ 8'h01;
    v[6].e_crc = 1;
    v[7]  = '{"null_then_short",10, {8'h09,8'h00,8'h00,8'h09,8'hFF,8'hFF,8'h05,8'h11,8'h00,8'h36,16'h0}, 0, 2, 'h05, 'h0011, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    v[8]  = '{"len_err",       10, {8'h39,8'h88,8'h13,8'h1A,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,16'h0}, 0, 1, 'h39, 'h1388, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    v[9]  = '{"trunc_payload",  6, {8'h39,8'h03,8'h00,8'h09,8'h2C,8'hAA,48'h0},                    0, 1, 'h39, 'h0003,  1, 0, 0, 2, 0, 0, 0, 0, 0, 1};
    v[10] = '{"eot_on_short",   4, {8'h05,8'h11,8'h00,8'h36,64'h0},                                1, 1, 'h05, 'h0011,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[11] = '{"eot_on_long_hdr",4, {8'h39,8'h03,8'h00,8'h09,64'h0},                                1, 1, 'h39, 'h0003,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      snap();
      send(v[k].b, v[k].n, 1'b1, v[k].eot_mode);
      chk({v[k].name, ".hdr_count"}, n_hdr - s_hdr, v[k].e_hdr);
      if (n_hdr != s_hdr) begin
        chk({v[k].name, ".vc"}, m_vc, 0);
        chk({v[k].name, ".dt"}, m_dt, v[k].e_dt);
        chk({v[k].name, ".long"}, m_long, v[k].e_long);
        chk({v[k].name, ".ecc_corr"}, m_corr, v[k].e_corr);
        chk({v[k].name, ".ecc_err"}, m_err, v[k].e_err);
        if (v[k].e_err == 0) chk({v[k].name, ".wc"}, m_wc, v[k].e_wc);
      end
      chk({v[k].name, ".pl_count"}, pl_log.size() - s_pl, v[k].e_pl);
      if (pl_log.size() - s_pl == v[k].e_pl)
        for (int j = 0; j < v[k].e_pl; j++)
          chk({v[k].name, ".pl_data"}, pl_log[s_pl + j], v[k].b[4 + j]);
      chk({v[k].name, ".pl_last"}, n_last - s_last, v[k].e_last);
      chk({v[k].name, ".pkt_done"}, n_done - s_done, v[k].e_done);
      chk({v[k].name, ".pkt_done_nocrc"}, n_done2 - s_done2, v[k].e_done);
      if (n_done != s_done) chk({v[k].name, ".crc_err"}, m_crc, v[k].e_crc);
      if (n_done2 != s_done2) chk({v[k].name, ".crc_err_nocrc"}, m_crc2, v[k].e_crc2);
      chk({v[k].name, ".len_err"}, n_len - s_len, v[k].e_len);
      chk({v[k].name, ".trunc_err"}, n_trunc - s_trunc, v[k].e_trunc);
    end

    // Bytes without a start-of-transmission are ignored.
    snap();
    send(v[0].b, 4, 1'b0, 0);
    chk("no_sot.hdr_count", n_hdr - s_hdr, 0);

    // New sot in the middle of a payload restarts the decoder on this byte.
    snap();
    send({8'h39,8'h03,8'h00,8'h09,8'h2C,56'h0}, 5, 1'b1, 2);
    send(v[0].b, 4, 1'b1, 0);
    chk("restart.hdr_count", n_hdr - s_hdr, 2);
    chk("restart.dt", m_dt, 6'h05);
    chk("restart.trunc_err", n_trunc - s_trunc, 1);
    chk("restart.pl_last", n_last - s_last, 0);
    chk("restart.pkt_done", n_done - s_done, 0);

    // Asynchronous reset while a payload is streaming.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[5].b[i];
      in_sot   = (i == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sot   = 1'b0;
    chk("pre_reset.pl_valid", pl_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 all_zero("async_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    send(v[5].b, v[5].n, 1'b1, 0);
    chk("post_reset.hdr_count", n_hdr - s_hdr, 1);
    chk("post_reset.wc", m_wc, 16'h0003);
    chk("post_reset.pl_count", pl_log.size() - s_pl, 3);
    chk("post_reset.pkt_done", n_done - s_done, 1);
    chk("post_reset.crc_err", m_crc, 1'b0);

    chk("hdr_pl_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
